// File: rtl/fifo_axis_packer.sv
// Pops words from an always-appear FIFO and packs PACK of them into one AXI4-Stream beat.
// Each packet is a programmed number of beats; tlast marks the final one.
module fifo_axis_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_en,
  input  logic                       i_start,
  input  logic [LEN_WIDTH-1:0]       i_beats,
  input  logic                       i_valid,
  input  logic [DATA_WIDTH-1:0]      i_data,
  output logic                       o_rd,
  output logic [DATA_WIDTH*PACK-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       o_busy,
  output logic                       o_done
);

  // state | meaning
  // IDLE  | waiting for i_start; zero-length start only pulses o_done
  // RUN   | popping words into the pack buffer and loading beats
  // DRAIN | last beat loaded; waiting for its handshake

  localparam int IDX_W = $clog2(PACK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e                          state_q;
  logic [LEN_WIDTH-1:0]            beats_left_q;
  logic [IDX_W-1:0]                word_idx_q;
  logic [PACK-2:0][DATA_WIDTH-1:0] buf_q;
  logic [DATA_WIDTH*PACK-1:0]      tdata_q;
  logic                            tvalid_q;
  logic                            tlast_q;
  logic                            done_q;

  logic last_word;
  logic slot_ok;
  logic rd;
  logic out_hs;

  assign last_word = (word_idx_q == LAST_IDX);
  // The closing word needs the output register free, or freeing by handshake this cycle.
  assign slot_ok   = !last_word || !tvalid_q || m_axis_tready;
  assign rd        = i_en && (state_q == S_RUN) && i_valid && slot_ok;
  assign out_hs    = tvalid_q && m_axis_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      beats_left_q <= '0;
      word_idx_q   <= '0;
      buf_q        <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (rd && last_word) begin
        tdata_q  <= {i_data, buf_q};
        tvalid_q <= 1'b1;
        tlast_q  <= (beats_left_q == LEN_WIDTH'(1));
      end else if (out_hs) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            if (i_beats != '0) begin
              state_q      <= S_RUN;
              beats_left_q <= i_beats;
              word_idx_q   <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (rd) begin
            if (last_word) begin
              word_idx_q   <= '0;
              beats_left_q <= beats_left_q - LEN_WIDTH'(1);
              if (beats_left_q == LEN_WIDTH'(1)) state_q <= S_DRAIN;
            end else begin
              for (int k = 0; k < PACK - 1; k++) begin
                if (word_idx_q == IDX_W'(k)) buf_q[k] <= i_data;
              end
              word_idx_q <= word_idx_q + IDX_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (out_hs && tlast_q) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_rd          = rd;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = done_q;

endmodule
